// File: rtl/backward_recursion.sv
// Anti-causal complex recursion y[n] = x[n] + a*y[n+1] over blocks of DEPTH samples.
// Input lands in a ping-pong buffer and each full bank is read back in reverse order.
module backward_recursion #(
  parameter int DEPTH     = 64,
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int FRAC_BITS = 14,
  parameter int FACTOR_R  = 0,
  parameter int FACTOR_I  = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_r,
  input  logic [DATA_W-1:0]        in_i,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_r,
  output logic [DATA_W-1:0]        out_i,
  output logic [$clog2(DEPTH)-1:0] out_idx,
  output logic                     out_last,
  output logic                     overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = DATA_W + COEF_W + 1;
  localparam int SW = PW + 1;
  localparam logic [AW-1:0]            LAST  = AW'(DEPTH - 1);
  localparam logic signed [COEF_W-1:0] C_R   = COEF_W'(FACTOR_R);
  localparam logic signed [COEF_W-1:0] C_I   = COEF_W'(FACTOR_I);
  localparam logic signed [SW-1:0]     MAX_V = SW'((longint'(1) <<< (DATA_W - 1)) - longint'(1));
  localparam logic signed [SW-1:0]     MIN_V = ~MAX_V;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  logic [2*DATA_W-1:0]      r_mem [2*DEPTH];
  logic [AW-1:0]            r_wrAddr, r_rdAddr, r_s1Idx;
  logic                     r_wrBank, r_rdBank;
  logic                     r_s1Valid, r_s1First, r_s1Last;
  logic signed [DATA_W-1:0] r_s1R, r_s1I;
  state_t                   r_state, w_nextState;

  logic                     w_swapReq, w_swapOk, w_issue, w_issueFirst, w_issueLast;
  logic signed [DATA_W-1:0] w_yR, w_yI, w_satR, w_satI;
  logic signed [PW-1:0]     w_pRR, w_pII, w_pRI, w_pIR, w_prodR, w_prodI;
  logic signed [SW-1:0]     w_sumR, w_sumI;

  function automatic logic signed [DATA_W-1:0] sat(input logic signed [SW-1:0] v);
    if (v > MAX_V) return MAX_V[DATA_W-1:0];
    if (v < MIN_V) return MIN_V[DATA_W-1:0];
    return v[DATA_W-1:0];
  endfunction

  // A swap is accepted unless a pass is still mid-way; the final read cycle may hand over directly.
  assign w_swapReq = in_valid && (r_wrAddr == LAST);
  assign w_swapOk  = w_swapReq && ((r_state != READ) || w_issueLast);

  always_ff @(posedge clk) begin
    if (in_valid) r_mem[{r_wrBank, r_wrAddr}] <= {in_i, in_r};
    {r_s1I, r_s1R} <= r_mem[{r_rdBank, r_rdAddr}];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrAddr <= '0;
      r_wrBank <= 1'b0;
      r_rdAddr <= '0;
      r_rdBank <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (in_valid) begin
        r_wrAddr <= (r_wrAddr == LAST) ? '0 : r_wrAddr + AW'(1);
        if (w_swapOk) r_wrBank <= ~r_wrBank;
      end
      if (w_swapOk) begin
        r_rdBank <= r_wrBank;
        r_rdAddr <= LAST;
      end else if (w_issue && !w_issueLast) begin
        r_rdAddr <= r_rdAddr - AW'(1);
      end
      // A rejected swap keeps the write bank, so the discarded block never touches the bank being read.
      if (w_swapReq && !w_swapOk) overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_swapOk) w_nextState = READ;
      READ:    if (w_issueLast) w_nextState = w_swapOk ? READ : DRAIN;
      DRAIN: begin
        if (w_swapOk)                     w_nextState = READ;
        else if (r_s1Valid && r_s1Last)   w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_issue      = (r_state == READ);
    w_issueFirst = w_issue && (r_rdAddr == LAST);
    w_issueLast  = w_issue && (r_rdAddr == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1Valid <= 1'b0;
      r_s1First <= 1'b0;
      r_s1Last  <= 1'b0;
      r_s1Idx   <= '0;
    end else begin
      r_s1Valid <= w_issue;
      r_s1First <= w_issueFirst;
      r_s1Last  <= w_issueLast;
      r_s1Idx   <= r_rdAddr;
    end
  end

  // The previous output register is the recursion state; the first sample of a pass sees zero.
  assign w_yR    = r_s1First ? '0 : $signed(out_r);
  assign w_yI    = r_s1First ? '0 : $signed(out_i);
  assign w_pRR   = PW'(C_R) * PW'(w_yR);
  assign w_pII   = PW'(C_I) * PW'(w_yI);
  assign w_pRI   = PW'(C_R) * PW'(w_yI);
  assign w_pIR   = PW'(C_I) * PW'(w_yR);
  assign w_prodR = (w_pRR - w_pII) >>> FRAC_BITS;
  assign w_prodI = (w_pRI + w_pIR) >>> FRAC_BITS;
  assign w_sumR  = SW'(w_prodR) + SW'(r_s1R);
  assign w_sumI  = SW'(w_prodI) + SW'(r_s1I);
  assign w_satR  = sat(w_sumR);
  assign w_satI  = sat(w_sumI);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_r     <= '0;
      out_i     <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= r_s1Valid;
      if (r_s1Valid) begin
        out_r    <= w_satR;
        out_i    <= w_satI;
        out_idx  <= r_s1Idx;
        out_last <= r_s1Last;
      end
    end
  end

endmodule

// File: tb/tb_backward_recursion.sv
// Bench for backward_recursion: three instances with different coefficients share one input stream
// and are checked against a plain-arithmetic model of the block recursion.
module tb_backward_recursion;

  localparam int L    = 4;
  localparam int FB   = 8;
  localparam int CR_C = -93;
  localparam int CI_C = 201;

  logic        clk = 1'b0;
  logic        rst, in_valid;
  logic [15:0] in_r, in_i;
  logic        vA, vB, vC, lastA, lastB, lastC, ovA, ovB, ovC;
  logic [15:0] rA, iA, rB, iB, rC, iC;
  logic [1:0]  idxA, idxB, idxC;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int r;
    int i;
    int idx;
    int last;
    int t;
  } out_t;

  out_t qA[$];
  out_t qB[$];
  out_t qC[$];

  backward_recursion #(.DEPTH(L), .DATA_W(16), .COEF_W(16), .FRAC_BITS(FB),
                       .FACTOR_R(128), .FACTOR_I(0)) dutA (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_r(in_r), .in_i(in_i),
    .out_valid(vA), .out_r(rA), .out_i(iA), .out_idx(idxA), .out_last(lastA), .overrun(ovA));

  backward_recursion #(.DEPTH(L), .DATA_W(16), .COEF_W(16), .FRAC_BITS(FB),
                       .FACTOR_R(0), .FACTOR_I(128)) dutB (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_r(in_r), .in_i(in_i),
    .out_valid(vB), .out_r(rB), .out_i(iB), .out_idx(idxB), .out_last(lastB), .overrun(ovB));

  backward_recursion #(.DEPTH(L), .DATA_W(16), .COEF_W(16), .FRAC_BITS(FB),
                       .FACTOR_R(CR_C), .FACTOR_I(CI_C)) dutC (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_r(in_r), .in_i(in_i),
    .out_valid(vC), .out_r(rC), .out_i(iC), .out_idx(idxC), .out_last(lastC), .overrun(ovC));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic out_t mk(input logic [15:0] r, input logic [15:0] i,
                              input logic [1:0] idx, input logic last, input int t);
    out_t o;
    o.r    = int'($signed(r));
    o.i    = int'($signed(i));
    o.idx  = int'(idx);
    o.last = int'(last);
    o.t    = t;
    return o;
  endfunction

  always @(negedge clk) begin
    if (vA) qA.push_back(mk(rA, iA, idxA, lastA, cyc));
    if (vB) qB.push_back(mk(rB, iB, idxB, lastB, cyc));
    if (vC) qC.push_back(mk(rC, iC, idxC, lastC, cyc));
  end

  function automatic int sat16(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  // y[n] = x[n] + a*y[n+1], y[L] = 0, products floored after scaling by 2^-FB.
  function automatic void model(input int xr[L], input int xi[L], input int cr, input int ci,
                                output int yr[L], output int yi[L]);
    longint pr, pi;
    int sr, si;
    sr = 0;
    si = 0;
    for (int n = L - 1; n >= 0; n--) begin
      pr = (longint'(cr) * sr - longint'(ci) * si) >>> FB;
      pi = (longint'(cr) * si + longint'(ci) * sr) >>> FB;
      yr[n] = sat16(xr[n] + pr);
      yi[n] = sat16(xi[n] + pi);
      sr = yr[n];
      si = yi[n];
    end
  endfunction

  function automatic int rnd16();
    return int'($signed(16'($urandom)));
  endfunction

  task automatic send_sample(input int r, input int i);
    in_valid = 1'b1;
    in_r     = 16'(r);
    in_i     = 16'(i);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    qA.delete();
    qB.delete();
    qC.delete();
  endtask

  task automatic test_reset();
    int xr[L];
    int xi[L];
    int yr[L];
    int yi[L];
    do_reset();
    for (int k = 0; k < L; k++) send_sample(rnd16(), rnd16());
    idle(2);
    rst = 1'b1;
    @(negedge clk);
    total++; if (vA !== 1'b0)     begin bad++; $display("[TB] FAIL reset_valid got=%b exp=0", vA); end
    total++; if (rA !== 16'd0)    begin bad++; $display("[TB] FAIL reset_out_r got=%0d exp=0", rA); end
    total++; if (iA !== 16'd0)    begin bad++; $display("[TB] FAIL reset_out_i got=%0d exp=0", iA); end
    total++; if (idxA !== 2'd0)   begin bad++; $display("[TB] FAIL reset_idx got=%0d exp=0", idxA); end
    total++; if (lastA !== 1'b0)  begin bad++; $display("[TB] FAIL reset_last got=%b exp=0", lastA); end
    total++; if (ovA !== 1'b0)    begin bad++; $display("[TB] FAIL reset_overrun got=%b exp=0", ovA); end
    rst = 1'b0;
    qA.delete();
    qC.delete();
    send_sample(rnd16(), rnd16());
    send_sample(rnd16(), rnd16());
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    qA.delete();
    qC.delete();
    for (int k = 0; k < L; k++) begin
      xr[k] = rnd16();
      xi[k] = rnd16();
      send_sample(xr[k], xi[k]);
    end
    idle(10);
    total++; if (qA.size() != L) begin bad++; $display("[TB] FAIL midreset_count got=%0d exp=%0d", qA.size(), L); end
    model(xr, xi, 128, 0, yr, yi);
    if (qA.size() >= L)
      for (int k = 0; k < L; k++) begin
        total++;
        if (qA[k].r != yr[L-1-k] || qA[k].i != yi[L-1-k]) begin
          bad++;
          $display("[TB] FAIL midreset_A[%0d] got=(%0d,%0d) exp=(%0d,%0d)", k, qA[k].r, qA[k].i, yr[L-1-k], yi[L-1-k]);
        end
      end
    model(xr, xi, CR_C, CI_C, yr, yi);
    total++; if (qC.size() != L) begin bad++; $display("[TB] FAIL midreset_countC got=%0d exp=%0d", qC.size(), L); end
    if (qC.size() >= L)
      for (int k = 0; k < L; k++) begin
        total++;
        if (qC[k].r != yr[L-1-k] || qC[k].i != yi[L-1-k]) begin
          bad++;
          $display("[TB] FAIL midreset_C[%0d] got=(%0d,%0d) exp=(%0d,%0d)", k, qC[k].r, qC[k].i, yr[L-1-k], yi[L-1-k]);
        end
      end
  endtask

  task automatic test_directed_real();
    int xin[L]  = '{256, 512, 768, 1024};
    int expR[L] = '{1024, 1280, 1152, 832};
    int tIn;
    do_reset();
    tIn = 0;
    for (int k = 0; k < L; k++) begin
      tIn = cyc;
      send_sample(xin[k], 0);
    end
    idle(10);
    total++; if (qA.size() != L) begin bad++; $display("[TB] FAIL real_count got=%0d exp=%0d", qA.size(), L); end
    if (qA.size() >= L) begin
      for (int k = 0; k < L; k++) begin
        total++;
        if (qA[k].r != expR[k] || qA[k].i != 0) begin
          bad++;
          $display("[TB] FAIL real_val[%0d] got=(%0d,%0d) exp=(%0d,0)", k, qA[k].r, qA[k].i, expR[k]);
        end
        total++;
        if (qA[k].idx != L - 1 - k || qA[k].last != ((k == L - 1) ? 1 : 0)) begin
          bad++;
          $display("[TB] FAIL real_idx[%0d] got=idx%0d/last%0d exp=idx%0d", k, qA[k].idx, qA[k].last, L - 1 - k);
        end
      end
      total++;
      if (qA[0].t != tIn + 3) begin
        bad++;
        $display("[TB] FAIL real_latency got=%0d exp=%0d", qA[0].t - tIn, 3);
      end
    end
  endtask

  task automatic test_directed_imag();
    int xin[L]  = '{0, 0, 0, 1024};
    int expR[L] = '{1024, 0, -256, 0};
    int expI[L] = '{0, 512, 0, -128};
    do_reset();
    for (int k = 0; k < L; k++) send_sample(xin[k], 0);
    idle(10);
    total++; if (qB.size() != L) begin bad++; $display("[TB] FAIL imag_count got=%0d exp=%0d", qB.size(), L); end
    if (qB.size() >= L)
      for (int k = 0; k < L; k++) begin
        total++;
        if (qB[k].r != expR[k] || qB[k].i != expI[k]) begin
          bad++;
          $display("[TB] FAIL imag_val[%0d] got=(%0d,%0d) exp=(%0d,%0d)", k, qB[k].r, qB[k].i, expR[k], expI[k]);
        end
      end
  endtask

  task automatic test_saturation();
    int e;
    do_reset();
    for (int k = 0; k < L; k++) send_sample(32767, 32767);
    for (int k = 0; k < L; k++) send_sample(-32768, -32768);
    idle(10);
    total++; if (qA.size() != 2 * L) begin bad++; $display("[TB] FAIL sat_count got=%0d exp=%0d", qA.size(), 2 * L); end
    if (qA.size() >= 2 * L)
      for (int k = 0; k < 2 * L; k++) begin
        e = (k < L) ? 32767 : -32768;
        total++;
        if (qA[k].r != e || qA[k].i != e) begin
          bad++;
          $display("[TB] FAIL sat_val[%0d] got=(%0d,%0d) exp=(%0d,%0d)", k, qA[k].r, qA[k].i, e, e);
        end
      end
  endtask

  task automatic test_back_to_back();
    int xr[3*L];
    int xi[3*L];
    int br[L];
    int bi[L];
    int yr[L];
    int yi[L];
    do_reset();
    for (int k = 0; k < 3 * L; k++) begin
      xr[k] = rnd16();
      xi[k] = rnd16();
      send_sample(xr[k], xi[k]);
    end
    idle(10);
    total++; if (qA.size() != 3 * L) begin bad++; $display("[TB] FAIL b2b_countA got=%0d exp=%0d", qA.size(), 3 * L); end
    total++; if (qC.size() != 3 * L) begin bad++; $display("[TB] FAIL b2b_countC got=%0d exp=%0d", qC.size(), 3 * L); end
    if (qA.size() >= 3 * L && qC.size() >= 3 * L)
      for (int b = 0; b < 3; b++) begin
        for (int k = 0; k < L; k++) begin
          br[k] = xr[b*L + k];
          bi[k] = xi[b*L + k];
        end
        model(br, bi, 128, 0, yr, yi);
        for (int k = 0; k < L; k++) begin
          total++;
          if (qA[b*L+k].r != yr[L-1-k] || qA[b*L+k].i != yi[L-1-k]) begin
            bad++;
            $display("[TB] FAIL b2b_A[%0d] got=(%0d,%0d) exp=(%0d,%0d)", b*L+k, qA[b*L+k].r, qA[b*L+k].i, yr[L-1-k], yi[L-1-k]);
          end
        end
        model(br, bi, CR_C, CI_C, yr, yi);
        for (int k = 0; k < L; k++) begin
          total++;
          if (qC[b*L+k].r != yr[L-1-k] || qC[b*L+k].i != yi[L-1-k]) begin
            bad++;
            $display("[TB] FAIL b2b_C[%0d] got=(%0d,%0d) exp=(%0d,%0d)", b*L+k, qC[b*L+k].r, qC[b*L+k].i, yr[L-1-k], yi[L-1-k]);
          end
          total++;
          if (qC[b*L+k].t != qC[0].t + b*L + k || qC[b*L+k].idx != L - 1 - k) begin
            bad++;
            $display("[TB] FAIL b2b_timing[%0d] got=t%0d/idx%0d exp=t%0d/idx%0d", b*L+k, qC[b*L+k].t, qC[b*L+k].idx, qC[0].t + b*L + k, L - 1 - k);
          end
        end
      end
    total++;
    if ({ovA, ovB, ovC} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL b2b_overrun got=%b%b%b exp=000", ovA, ovB, ovC);
    end
  endtask

  task automatic test_random_gaps();
    int xr[6*L];
    int xi[6*L];
    int br[L];
    int bi[L];
    int yr[L];
    int yi[L];
    do_reset();
    for (int k = 0; k < 6 * L; k++) begin
      xr[k] = rnd16();
      xi[k] = rnd16();
      send_sample(xr[k], xi[k]);
      idle($urandom_range(0, 2));
    end
    idle(10);
    total++; if (qC.size() != 6 * L) begin bad++; $display("[TB] FAIL gaps_count got=%0d exp=%0d", qC.size(), 6 * L); end
    if (qC.size() >= 6 * L)
      for (int b = 0; b < 6; b++) begin
        for (int k = 0; k < L; k++) begin
          br[k] = xr[b*L + k];
          bi[k] = xi[b*L + k];
        end
        model(br, bi, CR_C, CI_C, yr, yi);
        for (int k = 0; k < L; k++) begin
          total++;
          if (qC[b*L+k].r != yr[L-1-k] || qC[b*L+k].i != yi[L-1-k] || qC[b*L+k].last != ((k == L - 1) ? 1 : 0)) begin
            bad++;
            $display("[TB] FAIL gaps_C[%0d] got=(%0d,%0d,last%0d) exp=(%0d,%0d)", b*L+k, qC[b*L+k].r, qC[b*L+k].i, qC[b*L+k].last, yr[L-1-k], yi[L-1-k]);
          end
        end
      end
  endtask

  task automatic test_overrun();
    int xr[L];
    int xi[L];
    int yr[L];
    int yi[L];
    do_reset();
    for (int k = 0; k < L; k++) begin
      xr[k] = rnd16();
      xi[k] = rnd16();
      send_sample(xr[k], xi[k]);
    end
    // The pass has just started; pretend a whole new block arrived at once.
    force dutA.r_wrAddr = 2'd3;
    in_valid = 1'b1;
    in_r     = 16'(rnd16());
    in_i     = 16'(rnd16());
    @(posedge clk);
    #1;
    release dutA.r_wrAddr;
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (ovA !== 1'b1) begin bad++; $display("[TB] FAIL overrun_set got=%b exp=1", ovA); end
    idle(10);
    model(xr, xi, 128, 0, yr, yi);
    total++; if (qA.size() != L) begin bad++; $display("[TB] FAIL overrun_count got=%0d exp=%0d", qA.size(), L); end
    if (qA.size() >= L)
      for (int k = 0; k < L; k++) begin
        total++;
        if (qA[k].r != yr[L-1-k] || qA[k].i != yi[L-1-k]) begin
          bad++;
          $display("[TB] FAIL overrun_pass[%0d] got=(%0d,%0d) exp=(%0d,%0d)", k, qA[k].r, qA[k].i, yr[L-1-k], yi[L-1-k]);
        end
      end
    total++; if (ovA !== 1'b1) begin bad++; $display("[TB] FAIL overrun_sticky got=%b exp=1", ovA); end
    total++; if (ovC !== 1'b0) begin bad++; $display("[TB] FAIL overrun_other got=%b exp=0", ovC); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (ovA !== 1'b0) begin bad++; $display("[TB] FAIL overrun_clear got=%b exp=0", ovA); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_r     = '0;
    in_i     = '0;
    @(negedge clk);
    test_reset();
    test_directed_real();
    test_directed_imag();
    test_saturation();
    test_back_to_back();
    test_random_gaps();
    test_overrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
